// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Chunk index width: ceil(log2(N/W)), never below one bit.
    function automatic int idx_width(input int n, input int w);
        int c;
        c = n / w;
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational W-bit unsigned compare of one operand chunk.
module chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ne,
    output logic         gt
);

    assign ne = (a != b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle N-bit magnitude comparator, W bits per cycle, MS chunk first,
// with optional early exit on the first differing chunk.
//
// state | meaning
// IDLE  | ready for start, last result held on eq/lt/gt
// BUSY  | walking chunks of the latched operands, MS chunk first
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int W     = 8,
    parameter bit EARLY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    localparam int C  = N / W;
    localparam int IW = idx_width(N, W);
    localparam logic [IW-1:0] IDX_LAST = IW'(C - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_t        state;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [IW-1:0] idx;
    logic          diff_seen;
    logic          diff_gt;

    logic          chunk_ne;
    logic          chunk_gt;
    logic          any_diff;
    logic          fin_gt;
    logic          finish;

    // Operands shift left each cycle, so the live chunk is always the top W bits.
    chunk_cmp #(.W(W)) u_chunk_cmp (
        .a  (op_a[N-1 -: W]),
        .b  (op_b[N-1 -: W]),
        .ne (chunk_ne),
        .gt (chunk_gt)
    );

    always_comb begin
        any_diff = diff_seen | chunk_ne;
        fin_gt   = diff_seen ? diff_gt : chunk_gt;
        finish   = (idx == IDX_LAST) || (EARLY && chunk_ne && !diff_seen);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            idx       <= '0;
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Flipping the sign bits maps two's-complement order onto unsigned order.
                        op_a      <= {a[N-1] ^ is_signed, a[N-2:0]};
                        op_b      <= {b[N-1] ^ is_signed, b[N-2:0]};
                        idx       <= '0;
                        diff_seen <= 1'b0;
                        diff_gt   <= 1'b0;
                        ready     <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        eq    <= !any_diff;
                        lt    <= any_diff & !fin_gt;
                        gt    <= any_diff & fin_gt;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        if (chunk_ne && !diff_seen) begin
                            diff_seen <= 1'b1;
                            diff_gt   <= chunk_gt;
                        end
                        idx  <= idx + IDX_ONE;
                        op_a <= op_a << W;
                        op_b <= op_b << W;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: directed table, hand-written multi-cycle sequences and
// randomized compares against an arithmetic reference model.
module tb_seq_magnitude_comparator;

    localparam int N = 32;
    localparam int W = 8;
    localparam int C = N / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start1 = 1'b0;
    logic         start0 = 1'b0;
    logic         is_signed = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;

    logic ready1, done1, eq1, lt1, gt1;
    logic ready0, done0, eq0, lt0, gt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.N(N), .W(W), .EARLY(1'b1)) dut_early (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_signed(is_signed),
        .a(a), .b(b), .ready(ready1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1)
    );

    seq_magnitude_comparator #(.N(N), .W(W), .EARLY(1'b0)) dut_const (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_signed(is_signed),
        .a(a), .b(b), .ready(ready0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: {eq,lt,gt} from plain signed/unsigned arithmetic.
    function automatic logic [2:0] ref_rel(input logic [N-1:0] va, input logic [N-1:0] vb, input bit sgn);
        if (va == vb) return 3'b100;
        if (sgn) return ($signed(va) < $signed(vb)) ? 3'b010 : 3'b001;
        return (va < vb) ? 3'b010 : 3'b001;
    endfunction

    // Reference latency: position of the first differing chunk, or C.
    function automatic int ref_lat(input logic [N-1:0] va, input logic [N-1:0] vb, input bit early);
        logic [N-1:0] d;
        d = va ^ vb;
        if (!early) return C;
        for (int k = 0; k < C; k++)
            if (d[N-1-k*W -: W] != '0) return k + 1;
        return C;
    endfunction

    // Issue one compare; lat = cycles from the start edge to done, -1 on timeout.
    task automatic run_cmp(input bit early, input logic [N-1:0] va, input logic [N-1:0] vb,
                           input bit sgn, output int lat, output logic [2:0] flags);
        @(negedge clk);
        a = va;
        b = vb;
        is_signed = sgn;
        if (early) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start0 = 1'b0;
        lat = -1;
        flags = 3'b000;
        for (int n = 1; n <= C + 2; n++) begin
            @(posedge clk); #1;
            if (early ? done1 : done0) begin
                lat = n;
                flags = early ? {eq1, lt1, gt1} : {eq0, lt0, gt0};
                break;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        bit           sgn;
        bit           early;
        int           lat;
        logic [2:0]   flags;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int first_n;
        int ndone;
        logic [2:0] flags;
        logic [N-1:0] ra, rb;
        bit re, rs;

        vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 4, 3'b100};
        vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1, 3'b001};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1, 3'b010};
        vecs[3] = '{32'h000000FF, 32'h000000FE, 1'b0, 1'b1, 4, 3'b001};
        vecs[4] = '{32'h000000FF, 32'h000000FE, 1'b0, 1'b0, 4, 3'b001};
        vecs[5] = '{32'hFF000000, 32'h00000000, 1'b0, 1'b0, 4, 3'b001};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1, 4, 3'b001};
        vecs[7] = '{32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b1, 1, 3'b010};
        vecs[8] = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 4, 3'b100};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_early", {31'b0, ready1}, 32'd1);
        check("reset_done_early", {31'b0, done1}, 32'd0);
        check("reset_flags_early", {29'b0, eq1, lt1, gt1}, 32'd0);
        check("reset_ready_const", {31'b0, ready0}, 32'd1);
        check("reset_flags_const", {29'b0, eq0, lt0, gt0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_cmp(vecs[i].early, vecs[i].va, vecs[i].vb, vecs[i].sgn, lat, flags);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_flags", i), {29'b0, flags}, {29'b0, vecs[i].flags});
            check($sformatf("vec%0d_ready_at_done", i),
                  {31'b0, vecs[i].early ? ready1 : ready0}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_single", i),
                  {31'b0, vecs[i].early ? done1 : done0}, 32'd0);
        end

        // start held/re-pulsed while busy: only the first compare reports.
        @(negedge clk);
        a = 32'hAAAAAAAA;
        b = 32'hAAAAAAAA;
        is_signed = 1'b0;
        start1 = 1'b1;
        first_n = -1;
        ndone = 0;
        flags = 3'b000;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin a = 32'h01000000; b = 32'h0; end
            if (n == 1) begin a = 32'h0; b = 32'h01000000; end
            if (n == 2) start1 = 1'b0;
            if (done1) begin
                ndone++;
                if (first_n < 0) begin first_n = n; flags = {eq1, lt1, gt1}; end
            end
        end
        check("busy_start_latency", first_n, 32'd4);
        check("busy_start_ndone", ndone, 32'd1);
        check("busy_start_flags", {29'b0, flags}, 32'b100);

        // start held through the done cycle is accepted with no gap.
        @(negedge clk);
        a = 32'h01000000;
        b = 32'h0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        check("b2b_first_done", {31'b0, done1}, 32'd1);
        check("b2b_first_flags", {29'b0, eq1, lt1, gt1}, 32'b001);
        a = 32'h0;
        b = 32'h01000000;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b_accepted_ready", {31'b0, ready1}, 32'd0);
        check("b2b_gap_done", {31'b0, done1}, 32'd0);
        @(posedge clk); #1;
        check("b2b_second_done", {31'b0, done1}, 32'd1);
        check("b2b_second_flags", {29'b0, eq1, lt1, gt1}, 32'b010);

        // Reset in the middle of a 4-cycle compare abandons it.
        run_cmp(1'b1, 32'h01000000, 32'h0, 1'b0, lat, flags);
        check("pre_reset_flags", {29'b0, flags}, 32'b001);
        @(negedge clk);
        a = 32'h5A5A5A5A;
        b = 32'h5A5A5A5A;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_ready", {31'b0, ready1}, 32'd1);
        check("midreset_done", {31'b0, done1}, 32'd0);
        check("midreset_flags", {29'b0, eq1, lt1, gt1}, 32'd0);
        ndone = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        check("midreset_no_done", ndone, 32'd0);
        run_cmp(1'b1, 32'h00001234, 32'h00001200, 1'b0, lat, flags);
        check("post_reset_latency", lat, 32'd4);
        check("post_reset_flags", {29'b0, flags}, 32'b001);

        // Randomized compares; chunks are often copied so ties reach deep chunks.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            for (int k = 0; k < C; k++)
                if ($urandom_range(0, 2) != 0) rb[N-1-k*W -: W] = ra[N-1-k*W -: W];
            re = 1'(i % 2);
            rs = 1'($urandom_range(0, 1));
            run_cmp(re, ra, rb, rs, lat, flags);
            check($sformatf("rand%0d_latency", i), lat, ref_lat(ra, rb, re));
            check($sformatf("rand%0d_flags", i), {29'b0, flags}, {29'b0, ref_rel(ra, rb, rs)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
